jtsdram_stats: RTL and testbench

Downstream consumer of the SDRAM checker's status outputs. Counts completed test passes, bad-read events and per-bank read completions, and latches the pass of the first failure. It snapshots all counters once per frame at vertical-blank start, so the OSD/debug reader sees a coherent set. It also drives a status LED: blinking while healthy, solid once an error has been seen.

---
 rtl/jtsdram_pkg.sv | 15 +
 rtl/jtsdram_satcnt.sv | 24 ++
 rtl/jtsdram_stats.sv | 124 ++++++++++++
 tb/tb_jtsdram_stats.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtsdram_pkg.sv
// Shared constants for the SDRAM checker statistics block.
// Covers the default counter width, the shadow address map and the status word bit positions.
package jtsdram_pkg;
  localparam int CW_DEF = 16;

  localparam logic [2:0] STAT_PASS   = 3'd0;
  localparam logic [2:0] STAT_ERR    = 3'd1;
  localparam logic [2:0] STAT_FIRST  = 3'd2;
  localparam logic [2:0] STAT_STATUS = 3'd3;
  localparam logic [2:0] STAT_RD0    = 3'd4;

  localparam int ST_ERR  = 0;
  localparam int ST_BUSY = 1;
  localparam int ST_BAD  = 2;
endpackage

// File: rtl/jtsdram_satcnt.sv
// Event counter with synchronous clear.
// It either saturates at all-ones (SAT=1) or wraps (SAT=0).
module jtsdram_satcnt #(
  parameter int CW  = 16,
  parameter bit SAT = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !(SAT && (&cnt))) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/jtsdram_stats.sv
// Statistics for the SDRAM checker: pass/error/bank counters, frame-coherent shadows,
// a registered read port and a status LED (blinks while healthy, solid after an error).
module jtsdram_stats
  import jtsdram_pkg::*;
#(
  parameter int CW           = CW_DEF,
  parameter int BLINK_FRAMES = 30
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          LVBL,
  input  logic          dwnld_busy,
  input  logic          bad,
  input  logic [3:0]    ba_rdy,
  input  logic          clr,
  input  logic [2:0]    rd_addr,
  output logic [CW-1:0] rd_data,
  output logic          led,
  output logic          err_sticky
);

  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic          lvbl_prev, dwnld_prev, bad_prev;
  logic          frame_tick, pass_inc, bad_rise;
  logic [CW-1:0] pass_cnt, err_cnt, first_err_pass;
  logic [CW-1:0] rd_cnt [4];
  logic [CW-1:0] status_word;
  logic [CW-1:0] live   [8];
  logic [CW-1:0] shadow [8];
  logic [FW-1:0] frame_cnt;
  logic          blink;

  // Edge history survives clr so a held input cannot fake an edge afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvbl_prev  <= 1'b1;
      dwnld_prev <= 1'b0;
      bad_prev   <= 1'b0;
    end else begin
      lvbl_prev  <= LVBL;
      dwnld_prev <= dwnld_busy;
      bad_prev   <= bad;
    end
  end

  assign frame_tick = lvbl_prev & ~LVBL;
  assign pass_inc   = dwnld_prev & ~dwnld_busy;
  assign bad_rise   = ~bad_prev & bad;

  jtsdram_satcnt #(.CW(CW), .SAT(1'b1)) u_pass (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(pass_inc), .cnt(pass_cnt)
  );

  jtsdram_satcnt #(.CW(CW), .SAT(1'b1)) u_err (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(bad_rise), .cnt(err_cnt)
  );

  for (genvar n = 0; n < 4; n++) begin : g_bank
    jtsdram_satcnt #(.CW(CW), .SAT(1'b0)) u_rd (
      .clk(clk), .rst_n(rst_n), .clr(clr), .inc(ba_rdy[n]), .cnt(rd_cnt[n])
    );
  end

  always_comb begin
    status_word         = '0;
    status_word[ST_ERR]  = err_sticky;
    status_word[ST_BUSY] = dwnld_busy;
    status_word[ST_BAD]  = bad;
  end

  always_comb begin
    live[STAT_PASS]   = pass_cnt;
    live[STAT_ERR]    = err_cnt;
    live[STAT_FIRST]  = first_err_pass;
    live[STAT_STATUS] = status_word;
    for (int n = 0; n < 4; n++) begin
      live[int'(STAT_RD0) + n] = rd_cnt[n];
    end
  end

  // First failure snapshot and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky     <= 1'b0;
      first_err_pass <= '0;
    end else if (clr) begin
      err_sticky     <= 1'b0;
      first_err_pass <= '0;
    end else if (bad_rise && !err_sticky) begin
      err_sticky     <= 1'b1;
      first_err_pass <= pass_cnt;
    end
  end

  // Shadows sample the pre-update live values, so a coincident increment lands next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) shadow[i] <= '0;
      frame_cnt <= '0;
      blink     <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < 8; i++) shadow[i] <= '0;
      frame_cnt <= '0;
      blink     <= 1'b0;
    end else if (frame_tick) begin
      for (int i = 0; i < 8; i++) shadow[i] <= live[i];
      if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        blink     <= ~blink;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= shadow[rd_addr];
  end

  assign led = err_sticky | blink;

endmodule

// File: tb/tb_jtsdram_stats.sv
// Directed bench for jtsdram_stats: a 16-bit instance for function checks
// and a 4-bit instance to reach saturation/wrap quickly.
module tb_jtsdram_stats;

  logic        clk = 1'b0;
  logic        rst_n, LVBL, dwnld_busy, bad, clr;
  logic [3:0]  ba_rdy;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic        led, err_sticky;
  logic [3:0]  rd_data4;
  logic        led4, err_sticky4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  jtsdram_stats #(.CW(16), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .LVBL(LVBL), .dwnld_busy(dwnld_busy), .bad(bad),
    .ba_rdy(ba_rdy), .clr(clr), .rd_addr(rd_addr), .rd_data(rd_data),
    .led(led), .err_sticky(err_sticky)
  );

  jtsdram_stats #(.CW(4), .BLINK_FRAMES(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .LVBL(LVBL), .dwnld_busy(dwnld_busy), .bad(bad),
    .ba_rdy(ba_rdy), .clr(clr), .rd_addr(rd_addr), .rd_data(rd_data4),
    .led(led4), .err_sticky(err_sticky4)
  );

  typedef struct {
    string       name;
    logic [2:0]  addr;
    logic [15:0] exp;
  } rd_vec_t;

  rd_vec_t vq[$];

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [2:0] a);
    rd_addr = a;
    step();
  endtask

  task automatic add(input string name, input logic [2:0] a, input logic [15:0] e);
    rd_vec_t v;
    v.name = name;
    v.addr = a;
    v.exp  = e;
    vq.push_back(v);
  endtask

  task automatic run_vq();
    foreach (vq[i]) begin
      rd(vq[i].addr);
      check(vq[i].name, rd_data, vq[i].exp);
    end
    vq.delete();
  endtask

  task automatic frame_tick();
    LVBL = 1'b0;
    step();
    LVBL = 1'b1;
    step();
  endtask

  task automatic pass_pulse();
    dwnld_busy = 1'b1;
    step();
    dwnld_busy = 1'b0;
    step();
  endtask

  task automatic bad_pulse();
    bad = 1'b1;
    step();
    bad = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step();
  endtask

  logic led_exp [9];

  initial begin
    rst_n = 1'b0; LVBL = 1'b1; dwnld_busy = 1'b0; bad = 1'b0;
    clr = 1'b0; ba_rdy = 4'b0; rd_addr = 3'd0;
    step(5);
    rst_n = 1'b1;
    step(100);

    // Idle after reset
    for (int a = 0; a < 8; a++) add($sformatf("reset_addr%0d", a), 3'(a), 16'h0000);
    run_vq();
    check("reset_led", {15'b0, led}, 16'h0);
    check("reset_sticky", {15'b0, err_sticky}, 16'h0);

    // Pass counting and bank read counters
    repeat (3) pass_pulse();
    frame_tick();
    add("pass_cnt_3", 3'd0, 16'd3);
    add("status_idle", 3'd3, 16'd0);
    run_vq();
    ba_rdy = 4'b1111;
    step(5);
    ba_rdy = 4'b0000;
    frame_tick();
    for (int a = 4; a < 8; a++) add($sformatf("rd_cnt%0d_5", a - 4), 3'(a), 16'd5);
    add("pass_cnt_kept", 3'd0, 16'd3);
    run_vq();

    // Error capture
    do_reset();
    repeat (2) pass_pulse();
    repeat (3) bad_pulse();
    frame_tick();
    add("err_cnt_3", 3'd1, 16'd3);
    add("first_err_2", 3'd2, 16'd2);
    add("status_sticky", 3'd3, 16'd1);
    add("pass_cnt_2", 3'd0, 16'd2);
    run_vq();
    check("err_led_solid", {15'b0, led}, 16'h1);
    check("err_sticky_set", {15'b0, err_sticky}, 16'h1);
    frame_tick();
    check("err_led_solid_after_wrap", {15'b0, led}, 16'h1);

    // LED blink with BLINK_FRAMES=2
    do_reset();
    for (int i = 0; i < 9; i++) led_exp[i] = ((i / 2) % 2) == 1;
    check("blink_tick0", {15'b0, led}, {15'b0, led_exp[0]});
    for (int i = 1; i < 9; i++) begin
      frame_tick();
      check($sformatf("blink_tick%0d", i), {15'b0, led}, {15'b0, led_exp[i]});
    end

    // Saturation and wrap on the 4-bit instance
    do_reset();
    repeat (14) pass_pulse();
    ba_rdy = 4'b0001;
    step(15);
    ba_rdy = 4'b0000;
    frame_tick();
    rd(3'd0);
    check("sat_pass_14", {12'b0, rd_data4}, 16'd14);
    rd(3'd4);
    check("wrap_rd0_15", {12'b0, rd_data4}, 16'd15);
    repeat (3) pass_pulse();
    ba_rdy = 4'b0001;
    step();
    ba_rdy = 4'b0000;
    frame_tick();
    rd(3'd0);
    check("sat_pass_max", {12'b0, rd_data4}, 16'd15);
    rd(3'd4);
    check("wrap_rd0_0", {12'b0, rd_data4}, 16'd0);

    // clr against a simultaneous bad edge and frame tick
    do_reset();
    pass_pulse();
    ba_rdy = 4'b0100;
    step(3);
    ba_rdy = 4'b0000;
    frame_tick();
    rd(3'd6);
    check("pre_clr_rd2", rd_data, 16'd3);
    bad = 1'b1; LVBL = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0; LVBL = 1'b1; bad = 1'b0;
    step();
    check("clr_sticky", {15'b0, err_sticky}, 16'h0);
    check("clr_led", {15'b0, led}, 16'h0);
    for (int a = 0; a < 8; a++) add($sformatf("clr_shadow%0d", a), 3'(a), 16'h0000);
    run_vq();
    frame_tick();
    add("clr_err_cnt", 3'd1, 16'd0);
    add("clr_pass_cnt", 3'd0, 16'd0);
    add("clr_first", 3'd2, 16'd0);
    add("clr_status", 3'd3, 16'd0);
    run_vq();
    ba_rdy = 4'b0010;
    step();
    ba_rdy = 4'b0000;
    LVBL = 1'b0;
    step();
    LVBL = 1'b1;
    step();
    rd(3'd5);
    check("tick_after_rdy1", rd_data, 16'd1);

    // Read coincident with a shadow update returns the old value
    rd_addr = 3'd5;
    ba_rdy  = 4'b0010;
    step();
    ba_rdy  = 4'b0000;
    LVBL    = 1'b0;
    step();
    check("read_old_shadow", rd_data, 16'd1);
    LVBL = 1'b1;
    step();
    check("read_new_shadow", rd_data, 16'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
